// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Shares one UART transmitter among NUM_REQ byte sources; times each
//            frame slot itself. Define UART_ARB_FIXED_PRIO_EN for fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BAUD_DIV   = 10416,
    parameter int FRAME_BITS = 12,
    parameter int HOLD_CYC   = BAUD_DIV + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDW      = $clog2(NUM_REQ);
    localparam int SLOT_CYC = FRAME_BITS * BAUD_DIV;
    localparam int TW       = $clog2(SLOT_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t         r_state;
    logic [TW-1:0]  r_timer;
    logic [IDW-1:0] r_ptr;

    logic           w_found;
    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_idx;
    logic [IDW-1:0] w_ptr_nxt;
    logic [7:0]     w_win_data;
    logic           w_accept;

    // First valid requester found scanning upward from the pointer, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // rst_n gating keeps req_ready low while reset is asserted.
    assign w_accept = rst_n && en && w_found && (r_state == S_IDLE);

    always_comb begin
        req_ready  = '0;
        w_win_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_win == IDW'(j)) begin
                w_win_data   = req_data[8*j +: 8];
                req_ready[j] = w_accept;
            end
        end
    end

`ifdef UART_ARB_FIXED_PRIO_EN
    assign w_ptr_nxt = '0;
`else
    assign w_ptr_nxt = (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + IDW'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_ptr    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        tx_data  <= w_win_data;
                        grant_id <= w_win;
                        r_timer  <= '0;
                        r_ptr    <= w_ptr_nxt;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    r_timer <= r_timer + TW'(1);
                    if (r_timer == TW'(HOLD_CYC - 1)) begin
                        tx_start <= 1'b0;
                        r_state  <= S_GAP;
                    end
                end
                S_GAP: begin
                    // Slot ends a full frame after the first tx_start cycle.
                    if (r_timer == TW'(SLOT_CYC - 1)) begin
                        r_timer <= '0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Scoreboard bench for uart_tx_arbiter (BAUD_DIV=4, 48-cycle slot).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NR   = 4;
    localparam int BD   = 4;
    localparam int FB   = 12;
    localparam int HC   = 6;
    localparam int SLOT = 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    wire  [3:0]  req_ready;
    wire         tx_start;
    wire  [7:0]  tx_data;
    wire         busy;
    wire  [1:0]  grant_id;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .BAUD_DIV(BD), .FRAME_BITS(FB), .HOLD_CYC(HC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    int         acc_cyc[$];
    int         checks = 0;
    int         errors = 0;
    int         slot_n = 0;
    int         accepts = 0;
    int         cyc = 0;
    logic [7:0] cur_data = '0;
    logic [1:0] cur_id = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks slot shape after each accept and pops the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            slot_n = 0;
        end else begin
            if (slot_n > 0) begin
                chk("tx_start", {31'd0, tx_start}, {31'd0, slot_n <= HC});
                chk("busy", {31'd0, busy}, {31'd0, slot_n <= SLOT});
                if (slot_n <= SLOT) begin
                    chk("tx_data", {24'd0, tx_data}, {24'd0, cur_data});
                    chk("grant_id", {30'd0, grant_id}, {30'd0, cur_id});
                end
                slot_n++;
                if (slot_n > SLOT + 1) slot_n = 0;
            end
            if (req_ready != 4'b0000) begin
                accepts++;
                acc_cyc.push_back(cyc);
                if (q.size() == 0) begin
                    chk("unexpected_accept", {28'd0, req_ready}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("req_ready", {28'd0, req_ready}, {28'd0, 4'b0001 << e.id});
                    cur_data = e.data;
                    cur_id   = e.id;
                end
                slot_n = 1;
            end
        end
    end

    task automatic push(input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic wait_accepts(input int target, input int maxc);
        int n = 0;
        while (accepts < target && n < maxc) begin
            tick();
            n++;
        end
        if (accepts < target) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%0d expected=%0d", accepts, target);
        end
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((q.size() != 0 || slot_n != 0) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", q.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [1:0] t6_ids [3];
    int base;

    initial begin
`ifdef UART_ARB_FIXED_PRIO_EN
        t6_ids[0] = 2'd0; t6_ids[1] = 2'd0; t6_ids[2] = 2'd0;
`else
        t6_ids[0] = 2'd0; t6_ids[1] = 2'd1; t6_ids[2] = 2'd3;
`endif
        // Reset state, with a pending request that must not be accepted.
        en        = 1'b1;
        req_valid = 4'b0001;
        repeat (3) tick();
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        tick();

        // 1: single request
        req_data = 32'h0000_00A5;
        push(2'd0, 8'hA5);
        req_valid = 4'b0001;
        wait_accepts(accepts + 1, 5);
        req_valid = 4'b0000;
        drain(80);

        // 2: round-robin fairness with spacing
        do_reset();
        base     = accepts;
        req_data = 32'h1312_1110;
        push(2'd0, 8'h10); push(2'd1, 8'h11); push(2'd3, 8'h13);
        push(2'd0, 8'h10); push(2'd1, 8'h11); push(2'd3, 8'h13);
        req_valid = 4'b1011;
        wait_accepts(base + 6, 400);
        req_valid = 4'b0000;
        drain(80);
        for (int k = acc_cyc.size() - 6; k < acc_cyc.size() - 1; k++)
            chk("rr_spacing", acc_cyc[k+1] - acc_cyc[k], SLOT + 1);

        // 3: enable gating
        base      = accepts;
        en        = 1'b0;
        req_data  = 32'h0033_0000;
        req_valid = 4'b0100;
        repeat (100) tick();
        chk("en_gate_none", accepts, base);
        push(2'd2, 8'h33);
        en = 1'b1;
        wait_accepts(base + 1, 1);
        repeat (20) tick();
        en = 1'b0;
        drain(60);
        repeat (100) tick();
        chk("en_gate_after", accepts, base + 1);
        chk("en_gate_busy", {31'd0, busy}, 32'd0);
        req_valid = 4'b0000;
        en        = 1'b1;

        // 4: reset mid-HOLD
        req_data = 32'h4400_005A;
        push(2'd0, 8'h5A);
        req_valid = 4'b0001;
        wait_accepts(accepts + 1, 5);
        req_valid = 4'b1000;
        #20;
        chk("pre_rst_tx_start", {31'd0, tx_start}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("arst_req_ready", {28'd0, req_ready}, 32'd0);
        repeat (2) tick();
        push(2'd3, 8'h44);
        rst_n = 1'b1;
        wait_accepts(accepts + 1, 5);
        req_valid = 4'b0000;
        drain(80);
        chk("rst_grant3_id", {30'd0, grant_id}, 32'd3);

        // 5: data stability during GAP
        req_data = 32'h0000_00A5;
        push(2'd0, 8'hA5);
        req_valid = 4'b0001;
        wait_accepts(accepts + 1, 5);
        req_valid = 4'b0000;
        repeat (20) tick();
        req_data = 32'h0000_00FF;
        drain(80);

        // 6: priority mode
        do_reset();
        base     = accepts;
        req_data = 32'h1312_1110;
        for (int k = 0; k < 3; k++) push(t6_ids[k], 8'h10 + {6'd0, t6_ids[k]});
        req_valid = 4'b1011;
        wait_accepts(base + 3, 200);
        req_valid = 4'b0000;
        drain(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
